// File: rtl/gpio_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pkg
//  Description : Shared widths, defaults and pin-bundle types for the GPIO
//                input conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int GPIO_DATA_W           = 8;
    localparam int GPIO_CTRL_W           = 4;
    localparam int GPIO_PIN_W            = GPIO_DATA_W + GPIO_CTRL_W;
    localparam int GPIO_DEBOUNCE_DEFAULT = 16;
    localparam int GPIO_CNT_W_DEFAULT    = 16;

    typedef logic [GPIO_DATA_W-1:0] gpio_data_t;
    typedef logic [GPIO_CTRL_W-1:0] gpio_ctrl_t;

    // Control occupies the upper bits so a flat {control, data} vector maps directly.
    typedef struct packed {
        gpio_ctrl_t ctrl;
        gpio_data_t data;
    } gpio_pins_t;

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_input_conditioner_if
//  Description : Pin-side inputs and bus-side outputs of the conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpio_input_conditioner_if;
    import gpio_pkg::*;

    gpio_data_t i_pin_data;
    gpio_ctrl_t i_pin_control;
    gpio_ctrl_t i_edge_clear;
    gpio_data_t o_gpio_data;
    gpio_ctrl_t o_gpio_control;
    gpio_ctrl_t o_edge_flags;
    logic       o_change;

    modport master (
        output i_pin_data,
        output i_pin_control,
        output i_edge_clear,
        input  o_gpio_data,
        input  o_gpio_control,
        input  o_edge_flags,
        input  o_change
    );

    modport slave (
        input  i_pin_data,
        input  i_pin_control,
        input  i_edge_clear,
        output o_gpio_data,
        output o_gpio_control,
        output o_edge_flags,
        output o_change
    );

endinterface : gpio_input_conditioner_if
`default_nettype wire

// File: rtl/gpio_input_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce_bit
//  Description : Two-flop synchronizer plus counting debouncer for one pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = GPIO_CNT_W_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_stable,
    output logic o_update
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = r_sync2 ^ r_stable;
    // Accept on the edge the count would reach DEBOUNCE_CYCLES, so it never exceeds DEBOUNCE_CYCLES-1.
    assign w_accept  = w_differs && (r_cnt == c_cnt_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (!w_differs || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_stable <= r_sync2;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_update = w_accept;

endmodule : gpio_debounce_bit
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_input_conditioner
//  Description : Debounces 8 data and 4 control pins, keeps sticky rising-edge
//                flags on control and pulses a change indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = GPIO_CNT_W_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    gpio_input_conditioner_if.slave bus
);

    logic [GPIO_PIN_W-1:0] w_pin_vec;
    logic [GPIO_PIN_W-1:0] w_stable_vec;
    logic [GPIO_PIN_W-1:0] w_update_vec;
    gpio_pins_t            w_stable;
    gpio_pins_t            w_update;
    gpio_ctrl_t            w_ctrl_rise;

    gpio_ctrl_t            r_edge_flags;
    logic [GPIO_PIN_W-1:0] r_stable_q;
    logic                  r_change;

    assign w_pin_vec = {bus.i_pin_control, bus.i_pin_data};

    for (genvar gi = 0; gi < GPIO_PIN_W; gi++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_pin    (w_pin_vec[gi]),
            .o_stable (w_stable_vec[gi]),
            .o_update (w_update_vec[gi])
        );
    end

    assign w_stable    = gpio_pins_t'(w_stable_vec);
    assign w_update    = gpio_pins_t'(w_update_vec);
    // A control bit rises when it is accepted while currently low.
    assign w_ctrl_rise = w_update.ctrl & ~w_stable.ctrl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_edge_flags <= '0;
            r_stable_q   <= '0;
            r_change     <= 1'b0;
        end else begin
            r_edge_flags <= (r_edge_flags & ~bus.i_edge_clear) | w_ctrl_rise;
            r_stable_q   <= w_stable_vec;
            r_change     <= |(w_stable_vec ^ r_stable_q);
        end
    end

    assign bus.o_gpio_data    = w_stable.data;
    assign bus.o_gpio_control = w_stable.ctrl;
    assign bus.o_edge_flags   = r_edge_flags;
    assign bus.o_change       = r_change;

endmodule : gpio_input_conditioner
`default_nettype wire
